// File: rtl/cp0_if.sv
// cp0_if: M-stage side bundle of the coprocessor-0 controller.
//   master : pipeline side; drives the mtc0/mfc0 request, victim PC, delay-slot
//            flag, exception code, hardware interrupt lines and eret.
//   slave  : cp0 side; returns mfc0 read data, the stored EPC and the
//            take-exception request.
interface cp0_if;
  logic        we;           // mtc0 write enable
  logic [4:0]  cp0_addr;     // CP0 register index
  logic [31:0] cp0_din;      // mtc0 write data
  logic [31:0] vpc;          // PC of the M-stage instruction
  logic        bd_in;        // M-stage instruction sits in a delay slot
  logic [4:0]  exc_code_in;  // exception code, 0 = none
  logic [5:0]  hw_int;       // level-sensitive hardware interrupts
  logic        eret;         // eret retiring in M
  logic [31:0] cp0_dout;     // mfc0 read data
  logic [31:0] epc_out;      // stored EPC
  logic        req;          // redirect to handler / flush

  modport master (
    output we, cp0_addr, cp0_din, vpc, bd_in, exc_code_in, hw_int, eret,
    input  cp0_dout, epc_out, req
  );

  modport slave (
    input  we, cp0_addr, cp0_din, vpc, bd_in, exc_code_in, hw_int, eret,
    output cp0_dout, epc_out, req
  );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt controller at the memory stage.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : cp0_if.slave bundle (mtc0/mfc0 access, victim PC, delay-slot flag,
//           exception code, hw interrupts, eret in; read data, EPC, req out)
// Registers: SR(12) IM/EXL/IE, Cause(13) BD/IP/ExcCode (read-only to mtc0),
// EPC(14) full width, PRId(15) constant PRID_VALUE. Other indices read 0.
module cp0 #(
  parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  // EPC
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc_next;

  // Request is purely combinational so the PC can redirect in the same cycle.
  assign w_int_req = (|(bus.hw_int & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (bus.exc_code_in != '0) & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  // A delay-slot victim restarts at the branch, one word earlier (wraps mod 2^32).
  assign w_epc_next = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      // Pending-interrupt view follows the lines every cycle, unconditionally.
      r_ip <= bus.hw_int;
      if (w_req) begin
        // Taking the exception swallows any mtc0/eret in the same cycle.
        r_exl      <= 1'b1;
        r_bd       <= bus.bd_in;
        r_epc      <= w_epc_next;
        r_exc_code <= w_int_req ? 5'd0 : bus.exc_code_in;
      end else begin
        if (bus.eret) begin
          r_exl <= 1'b0;
        end
        // Placed after eret so an mtc0 to SR decides EXL when both occur.
        if (bus.we) begin
          case (bus.cp0_addr)
            ADDR_SR: begin
              r_im  <= bus.cp0_din[15:10];
              r_exl <= bus.cp0_din[1];
              r_ie  <= bus.cp0_din[0];
            end
            ADDR_EPC: r_epc <= bus.cp0_din;
            default: ;
          endcase
        end
      end
    end
  end

  assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
  assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

  always_comb begin
    bus.cp0_dout = '0;
    case (bus.cp0_addr)
      ADDR_SR:    bus.cp0_dout = w_sr;
      ADDR_CAUSE: bus.cp0_dout = w_cause;
      ADDR_EPC:   bus.cp0_dout = r_epc;
      ADDR_PRID:  bus.cp0_dout = PRID_VALUE;
      default:    bus.cp0_dout = '0;
    endcase
  end

  assign bus.epc_out = r_epc;
  assign bus.req     = w_req;

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;

  localparam logic [31:0] PRID = 32'h2023_0007;

  logic clk;
  logic reset;

  cp0_if bus ();

  cp0 #(.PRID_VALUE(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  // Architectural reference state, kept as whole 32-bit register images.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  function automatic logic m_int(input logic [5:0] hw);
    return ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc(input logic [4:0] ec);
    return (ec != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] pc, input logic bd, input logic [4:0] ec,
                        input logic [5:0] hw, input logic er, input logic rs);
    logic ir, r;
    ir = m_int(hw);
    r  = ir || m_exc(ec);
    if (rs) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (r) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (32'(bd) << 31) | (32'(hw) << 10) | ((ir ? 32'd0 : 32'(ec)) << 2);
      m_epc   = bd ? pc - 32'd4 : pc;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      if (er) m_sr = m_sr & ~32'h2;
      if (w && a == 5'd12) m_sr = d & 32'h0000_FC03;
      if (w && a == 5'd14) m_epc = d;
    end
  endtask

  // One cycle: drive inputs, queue the expected combinational view, clock the model.
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] pc, input logic bd, input logic [4:0] ec,
                     input logic [5:0] hw, input logic er, input logic rs);
    exp_t e;
    bus.we = w; bus.cp0_addr = a; bus.cp0_din = d; bus.vpc = pc;
    bus.bd_in = bd; bus.exc_code_in = ec; bus.hw_int = hw; bus.eret = er;
    reset = rs;
    e.id   = n_cyc;
    e.req  = m_int(hw) || m_exc(ec);
    e.dout = m_read(a);
    e.epc  = m_epc;
    q.push_back(e);
    n_cyc++;
    @(posedge clk);
    m_step(w, a, d, pc, bd, ec, hw, er, rs);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    cyc(1'b0, a, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic do_eret();
    cyc(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
  endtask

  // Monitor: compares the DUT against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (bus.req !== e.req) begin
        n_fail++;
        $display("FAIL req cyc=%0d got=%0b exp=%0b", e.id, bus.req, e.req);
      end
      n_checks++;
      if (bus.cp0_dout !== e.dout) begin
        n_fail++;
        $display("FAIL cp0_dout cyc=%0d addr=%0d got=%08h exp=%08h",
                 e.id, bus.cp0_addr, bus.cp0_dout, e.dout);
      end
      n_checks++;
      if (bus.epc_out !== e.epc) begin
        n_fail++;
        $display("FAIL epc_out cyc=%0d got=%08h exp=%08h", e.id, bus.epc_out, e.epc);
      end
    end
  end

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1;
    bus.we = 0; bus.cp0_addr = 5'd12; bus.cp0_din = 0; bus.vpc = 0;
    bus.bd_in = 0; bus.exc_code_in = 0; bus.hw_int = 0; bus.eret = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd15);

    // Exception, not in delay slot
    cyc(1'b0, 5'd13, 32'h0, 32'h0000_3010, 1'b0, 5'd10, 6'd0, 1'b0, 1'b0);
    rd(5'd13); rd(5'd12); rd(5'd14);

    // Lockout while EXL: no request, EPC unchanged
    cyc(1'b0, 5'd14, 32'h0, 32'h0000_3500, 1'b0, 5'd7, 6'd0, 1'b0, 1'b0);
    rd(5'd14);

    // eret clears EXL; then an eret coinciding with req is ignored (delay slot)
    do_eret();
    rd(5'd12);
    cyc(1'b0, 5'd12, 32'h0, 32'h0000_3024, 1'b1, 5'd4, 6'd0, 1'b1, 1'b0);
    rd(5'd12); rd(5'd14); rd(5'd13);

    // Interrupt wins over exception
    do_eret();
    wr(5'd12, 32'h0000_0401);
    cyc(1'b0, 5'd13, 32'h0, 32'h0000_3100, 1'b0, 5'd4, 6'b000001, 1'b0, 1'b0);
    rd(5'd13); rd(5'd14); rd(5'd12);

    // Masked IM
    do_eret();
    wr(5'd12, 32'h0000_0001);
    cyc(1'b0, 5'd12, 32'h0, 32'h0000_3200, 1'b0, 5'd0, 6'b000001, 1'b0, 1'b0);
    rd(5'd13);

    // mtc0 masking; Cause read-only
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12);
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13);
    wr(5'd15, 32'h1234_5678);
    rd(5'd15);
    wr(5'd20, 32'h1234_5678);
    rd(5'd20);

    // eret and mtc0 SR together: mtc0 EXL wins
    cyc(1'b1, 5'd12, 32'h0000_FC03, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
    rd(5'd12);

    // req with mtc0 EPC in the same cycle: EPC takes vpc
    do_eret();
    cyc(1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_4444, 1'b0, 5'd3, 6'd0, 1'b0, 1'b0);
    rd(5'd14);

    // Delay-slot wrap: 0 - 4
    do_eret();
    cyc(1'b0, 5'd14, 32'h0, 32'h0000_0000, 1'b1, 5'd12, 6'd0, 1'b0, 1'b0);
    rd(5'd14); rd(5'd13);

    // Reset mid-handler
    cyc(1'b1, 5'd14, 32'h5555_5555, 32'h0000_7000, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
    rd(5'd12); rd(5'd14); rd(5'd13);

    // mtc0 EPC
    wr(5'd14, 32'h1234_5678);
    rd(5'd14);

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      logic        w, bd, er;
      logic [4:0]  a, ec;
      logic [31:0] d, pc;
      logic [5:0]  hw;
      w  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                        : 5'(12 + $urandom_range(0, 3));
      d  = $urandom;
      pc = ($urandom_range(0, 15) == 0) ? 32'h0 : {$urandom, 2'b00} >> 2 << 2;
      bd = 1'($urandom_range(0, 1));
      ec = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      er = ($urandom_range(0, 4) == 0);
      cyc(w, a, d, pc, bd, ec, hw, er, ($urandom_range(0, 99) == 0));
    end

    bus.we = 0; bus.exc_code_in = 0; bus.hw_int = 0; bus.eret = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
